// File: rtl/multi_motor_ramp_ctrl.sv
// rtl/multi_motor_ramp_ctrl.sv - N-channel ramped H-bridge driver with dead-timed reversal and e-stop
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   duty_sp             packed per-channel duty setpoints, channel k at [k*DUTY_W +: DUTY_W]
//   dir_req             requested direction per channel (1 = forward)
//   est_in              asynchronous emergency stop (reed switch), active-high
//   clear_fault         level-sensitive fault clear
//   motor_in3/in4/enb   registered H-bridge controls per channel
//   fault               emergency stop latched
//   ch_busy             channel ramping or in dead time

module multi_motor_ramp_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int PWM_PERIOD  = 5000,
  parameter int DUTY_W      = 13,
  parameter int RAMP_CYCLES = 50000,
  parameter int RAMP_STEP   = 100,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DUTY_W-1:0] duty_sp,
  input  logic [NUM_CH-1:0]        dir_req,
  input  logic                     est_in,
  input  logic                     clear_fault,
  output logic [NUM_CH-1:0]        motor_in3,
  output logic [NUM_CH-1:0]        motor_in4,
  output logic [NUM_CH-1:0]        motor_enb,
  output logic                     fault,
  output logic [NUM_CH-1:0]        ch_busy
);

  localparam int RAMP_W = $clog2(RAMP_CYCLES + 1);
  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

  localparam logic [DUTY_W-1:0] PERIOD_D    = DUTY_W'(PWM_PERIOD);
  localparam logic [DUTY_W-1:0] PERIOD_LAST = DUTY_W'(PWM_PERIOD - 1);
  localparam logic [DUTY_W-1:0] STEP_D      = DUTY_W'(RAMP_STEP);
  localparam logic [DUTY_W-1:0] DUTY_ONE    = DUTY_W'(1);
  localparam logic [RAMP_W-1:0] RAMP_LAST   = RAMP_W'(RAMP_CYCLES - 1);
  localparam logic [RAMP_W-1:0] RAMP_ONE    = RAMP_W'(1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD   = DEAD_W'(DEAD_CYCLES);
  localparam logic [DEAD_W-1:0] DEAD_ONE    = DEAD_W'(1);

  typedef enum logic {
    ST_DRIVE = 1'b0,
    ST_DEAD  = 1'b1
  } ch_state_t;

  logic              est_meta, est_s;
  logic              fault_d;
  logic [DUTY_W-1:0] pwm_cnt;
  logic [RAMP_W-1:0] ramp_cnt;
  logic              tick;

  ch_state_t         state_q    [NUM_CH];
  ch_state_t         state_d    [NUM_CH];
  logic [DUTY_W-1:0] duty_cur_q [NUM_CH];
  logic [DUTY_W-1:0] duty_cur_d [NUM_CH];
  logic [DUTY_W-1:0] duty_app_q [NUM_CH];
  logic [DUTY_W-1:0] duty_app_d [NUM_CH];
  logic [DEAD_W-1:0] dead_q     [NUM_CH];
  logic [DEAD_W-1:0] dead_d     [NUM_CH];
  logic [DUTY_W-1:0] sp_k       [NUM_CH];
  logic [DUTY_W-1:0] tgt_k      [NUM_CH];
  logic [NUM_CH-1:0] dir_cur_q, dir_cur_d;
  logic [NUM_CH-1:0] in3_d, in4_d, enb_d, busy_d;

  assign tick = (ramp_cnt == RAMP_LAST);

  // Clamped setpoint; a pending reversal forces the target to zero so the
  // channel ramps down before the bridge is allowed to switch.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      sp_k[k] = duty_sp[k*DUTY_W +: DUTY_W];
      if (sp_k[k] > PERIOD_D) sp_k[k] = PERIOD_D;
      tgt_k[k] = (dir_req[k] != dir_cur_q[k]) ? '0 : sp_k[k];
    end
  end

  always_comb begin
    fault_d   = fault;
    dir_cur_d = dir_cur_q;
    in3_d     = '0;
    in4_d     = '0;
    enb_d     = '0;
    busy_d    = '0;
    if (est_s)            fault_d = 1'b1;
    else if (clear_fault) fault_d = 1'b0;

    for (int k = 0; k < NUM_CH; k++) begin
      state_d[k]    = state_q[k];
      duty_cur_d[k] = duty_cur_q[k];
      duty_app_d[k] = duty_app_q[k];
      dead_d[k]     = dead_q[k];

      busy_d[k] = (state_q[k] == ST_DEAD) || (duty_cur_q[k] != tgt_k[k]) ||
                  (duty_app_q[k] != duty_cur_q[k]);

      // est_s gating makes the outputs drop on the same edge that latches fault.
      if ((state_q[k] == ST_DRIVE) && !est_s && !fault) begin
        enb_d[k] = (pwm_cnt < duty_app_q[k]);
        in3_d[k] = (duty_app_q[k] != '0) && dir_cur_q[k];
        in4_d[k] = (duty_app_q[k] != '0) && !dir_cur_q[k];
      end

      if (est_s || fault) begin
        // Immediate stop: no wait for the PWM period boundary, direction held.
        duty_cur_d[k] = '0;
        duty_app_d[k] = '0;
        state_d[k]    = ST_DRIVE;
        dead_d[k]     = '0;
      end else begin
        case (state_q[k])
          ST_DRIVE: begin
            if (tick) begin
              if (duty_cur_q[k] > tgt_k[k])
                duty_cur_d[k] = ((duty_cur_q[k] - tgt_k[k]) > STEP_D) ?
                                duty_cur_q[k] - STEP_D : tgt_k[k];
              else if (duty_cur_q[k] < tgt_k[k])
                duty_cur_d[k] = ((tgt_k[k] - duty_cur_q[k]) > STEP_D) ?
                                duty_cur_q[k] + STEP_D : tgt_k[k];
            end
            // Applied duty only changes at the end of a PWM period.
            if (pwm_cnt == PERIOD_LAST) duty_app_d[k] = duty_cur_q[k];
            if ((dir_req[k] != dir_cur_q[k]) && (duty_app_q[k] == '0) &&
                (duty_cur_q[k] == '0)) begin
              state_d[k] = ST_DEAD;
              dead_d[k]  = DEAD_LOAD;
            end
          end
          ST_DEAD: begin
            // The direction is sampled only as dead time expires, so a
            // request that toggles back mid-dead-time is simply honoured then.
            if (dead_q[k] <= DEAD_ONE) begin
              dead_d[k]    = '0;
              dir_cur_d[k] = dir_req[k];
              state_d[k]   = ST_DRIVE;
            end else begin
              dead_d[k] = dead_q[k] - DEAD_ONE;
            end
          end
          default: state_d[k] = ST_DRIVE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      est_meta  <= 1'b0;
      est_s     <= 1'b0;
      fault     <= 1'b0;
      pwm_cnt   <= '0;
      ramp_cnt  <= '0;
      dir_cur_q <= '0;
      motor_in3 <= '0;
      motor_in4 <= '0;
      motor_enb <= '0;
      ch_busy   <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k]    <= ST_DRIVE;
        duty_cur_q[k] <= '0;
        duty_app_q[k] <= '0;
        dead_q[k]     <= '0;
      end
    end else begin
      est_meta  <= est_in;
      est_s     <= est_meta;
      fault     <= fault_d;
      pwm_cnt   <= (pwm_cnt == PERIOD_LAST) ? '0 : pwm_cnt + DUTY_ONE;
      ramp_cnt  <= tick ? '0 : ramp_cnt + RAMP_ONE;
      dir_cur_q <= dir_cur_d;
      motor_in3 <= in3_d;
      motor_in4 <= in4_d;
      motor_enb <= enb_d;
      ch_busy   <= busy_d;
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k]    <= state_d[k];
        duty_cur_q[k] <= duty_cur_d[k];
        duty_app_q[k] <= duty_app_d[k];
        dead_q[k]     <= dead_d[k];
      end
    end
  end

endmodule

// File: tb/tb_multi_motor_ramp_ctrl.sv
// tb/tb_multi_motor_ramp_ctrl.sv - scoreboard bench for multi_motor_ramp_ctrl

module tb_multi_motor_ramp_ctrl;

  localparam int NUM_CH = 2;
  localparam int DUTY_W = 4;
  localparam int PER    = 10;

  localparam int K_WENB  = 0;
  localparam int K_WIN3  = 1;
  localparam int K_WIN4  = 2;
  localparam int K_FAULT = 3;
  localparam int K_BUSY  = 4;
  localparam int K_ENB   = 5;
  localparam int K_IN4   = 6;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_CH*DUTY_W-1:0] duty_sp;
  logic [NUM_CH-1:0]        dir_req;
  logic                     est_in;
  logic                     clear_fault;
  logic [NUM_CH-1:0]        motor_in3, motor_in4, motor_enb, ch_busy;
  logic                     fault;

  multi_motor_ramp_ctrl #(
    .NUM_CH(NUM_CH), .PWM_PERIOD(PER), .DUTY_W(DUTY_W),
    .RAMP_CYCLES(4), .RAMP_STEP(3), .DEAD_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .duty_sp(duty_sp), .dir_req(dir_req),
    .est_in(est_in), .clear_fault(clear_fault),
    .motor_in3(motor_in3), .motor_in4(motor_in4), .motor_enb(motor_enb),
    .fault(fault), .ch_busy(ch_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ep;
    int n;
    int kind;
    int ch;
    int val;
  } exp_t;

  exp_t q[$];
  exp_t mon_item;
  int   checks = 0;
  int   errors = 0;
  int   n_rel  = 0;
  int   epoch  = 0;
  int   enb_cnt  [NUM_CH];
  int   in3_seen [NUM_CH];
  int   in4_seen [NUM_CH];

  function automatic string kname(input int k);
    case (k)
      K_WENB:  return "win_enb_count";
      K_WIN3:  return "win_in3_seen";
      K_WIN4:  return "win_in4_seen";
      K_FAULT: return "fault";
      K_BUSY:  return "ch_busy";
      K_ENB:   return "enb";
      K_IN4:   return "in4";
      default: return "unknown";
    endcase
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Sorted insert by (epoch, cycle) so the monitor only ever looks at the head.
  task automatic expect_at(input int ep, input int n, input int kind, input int ch, input int val);
    exp_t it;
    int   i;
    it.ep = ep; it.n = n; it.kind = kind; it.ch = ch; it.val = val;
    i = q.size();
    while (i > 0 && (q[i-1].ep > ep || (q[i-1].ep == ep && q[i-1].n > n))) i--;
    q.insert(i, it);
  endtask

  // Window w spans output samples after edges 10w+1 .. 10w+10.
  task automatic win(input int ep, input int w, input int ch, input int enb);
    expect_at(ep, w*PER + PER, K_WENB, ch, enb);
  endtask

  task automatic win_dir(input int ep, input int w, input int ch, input int enb,
                         input int in3, input int in4);
    expect_at(ep, w*PER + PER, K_WENB, ch, enb);
    expect_at(ep, w*PER + PER, K_WIN3, ch, in3);
    expect_at(ep, w*PER + PER, K_WIN4, ch, in4);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) n_rel <= 0;
    else     n_rel <= n_rel + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        enb_cnt[c] = 0; in3_seen[c] = 0; in4_seen[c] = 0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        enb_cnt[c]  = enb_cnt[c] + int'(motor_enb[c]);
        in3_seen[c] = in3_seen[c] | int'(motor_in3[c]);
        in4_seen[c] = in4_seen[c] | int'(motor_in4[c]);
      end
      while (q.size() > 0 && (q[0].ep < epoch || (q[0].ep == epoch && q[0].n < n_rel))) begin
        mon_item = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed %s ch%0d ep%0d n%0d", kname(mon_item.kind), mon_item.ch,
                 mon_item.ep, mon_item.n);
      end
      while (q.size() > 0 && q[0].ep == epoch && q[0].n == n_rel) begin
        mon_item = q.pop_front();
        case (mon_item.kind)
          K_WENB:  check($sformatf("%s ch%0d ep%0d n%0d", kname(mon_item.kind), mon_item.ch, epoch, n_rel), enb_cnt[mon_item.ch], mon_item.val);
          K_WIN3:  check($sformatf("%s ch%0d ep%0d n%0d", kname(mon_item.kind), mon_item.ch, epoch, n_rel), in3_seen[mon_item.ch], mon_item.val);
          K_WIN4:  check($sformatf("%s ch%0d ep%0d n%0d", kname(mon_item.kind), mon_item.ch, epoch, n_rel), in4_seen[mon_item.ch], mon_item.val);
          K_FAULT: check($sformatf("%s ep%0d n%0d", kname(mon_item.kind), epoch, n_rel), int'(fault), mon_item.val);
          K_BUSY:  check($sformatf("%s ch%0d ep%0d n%0d", kname(mon_item.kind), mon_item.ch, epoch, n_rel), int'(ch_busy[mon_item.ch]), mon_item.val);
          K_ENB:   check($sformatf("%s ch%0d ep%0d n%0d", kname(mon_item.kind), mon_item.ch, epoch, n_rel), int'(motor_enb[mon_item.ch]), mon_item.val);
          default: check($sformatf("%s ch%0d ep%0d n%0d", kname(mon_item.kind), mon_item.ch, epoch, n_rel), int'(motor_in4[mon_item.ch]), mon_item.val);
        endcase
      end
      if (n_rel % PER == 0) begin
        for (int c = 0; c < NUM_CH; c++) begin
          enb_cnt[c] = 0; in3_seen[c] = 0; in4_seen[c] = 0;
        end
      end
    end
  end

  task automatic wait_n(input int k);
    while (n_rel < k) @(negedge clk);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    duty_sp     = {4'd0, 4'd7};
    dir_req     = 2'b01;
    est_in      = 1'b0;
    clear_fault = 1'b0;
    epoch       = 1;

    // Epoch 1: ch0 ramps forward after the initial dead time, then reverses;
    // ch1 is driven past full scale, trimmed, then everything is e-stopped.
    expect_at(1, 1, K_BUSY, 0, 0);
    expect_at(1, 2, K_BUSY, 0, 1);
    win(1, 0, 0, 0);
    win(1, 0, 1, 0);
    win_dir(1, 1, 0, 3, 1, 0);
    win_dir(1, 1, 1, 0, 0, 0);
    expect_at(1, 20, K_BUSY, 0, 1);
    expect_at(1, 21, K_BUSY, 0, 0);
    win_dir(1, 2, 0, 7, 1, 0);
    win(1, 3, 0, 7);
    win(1, 3, 1, 0);
    win_dir(1, 4, 0, 1, 1, 0);
    win_dir(1, 4, 1, 6, 0, 1);
    expect_at(1, 51, K_BUSY, 0, 0);
    expect_at(1, 51, K_BUSY, 1, 0);
    expect_at(1, 52, K_BUSY, 0, 1);
    expect_at(1, 54, K_BUSY, 0, 1);
    win_dir(1, 5, 0, 0, 0, 0);
    win(1, 5, 1, 10);
    win_dir(1, 6, 0, 3, 0, 1);
    win(1, 6, 1, 10);
    win_dir(1, 7, 0, 7, 0, 1);
    win(1, 7, 1, 10);
    win(1, 8, 0, 7);
    win(1, 8, 1, 10);
    win(1, 9, 0, 7);
    win(1, 9, 1, 7);
    expect_at(1, 102, K_FAULT, 0, 0);
    expect_at(1, 102, K_ENB, 0, 1);
    expect_at(1, 102, K_IN4, 0, 1);
    expect_at(1, 103, K_FAULT, 0, 1);
    expect_at(1, 103, K_ENB, 0, 0);
    expect_at(1, 103, K_IN4, 0, 0);
    expect_at(1, 103, K_ENB, 1, 0);
    expect_at(1, 115, K_FAULT, 0, 1);
    win_dir(1, 11, 0, 0, 0, 0);
    win_dir(1, 11, 1, 0, 0, 0);
    expect_at(1, 125, K_FAULT, 0, 1);
    expect_at(1, 126, K_FAULT, 0, 0);
    win(1, 12, 0, 0);
    win(1, 12, 1, 0);
    win_dir(1, 13, 0, 3, 0, 1);
    win_dir(1, 13, 1, 3, 0, 1);
    win(1, 14, 0, 7);
    win(1, 14, 1, 7);
    win(1, 15, 0, 7);
    expect_at(1, 153, K_BUSY, 0, 1);
    expect_at(1, 161, K_BUSY, 0, 0);
    win(1, 16, 0, 5);
    win(1, 16, 1, 7);
    win_dir(1, 17, 0, 5, 0, 1);
    expect_at(1, 181, K_BUSY, 0, 0);
    expect_at(1, 182, K_BUSY, 0, 1);
    expect_at(1, 182, K_ENB, 1, 1);

    #1 rst = 1'b1;
    #11 check("reset_outputs", int'({motor_in3, motor_in4, motor_enb, ch_busy, fault}), 0);
    #10 rst = 1'b0;

    wait_n(30);
    duty_sp[7:4] = 4'd15;
    dir_req[0]   = 1'b0;
    wait_n(80);
    duty_sp[7:4] = 4'd7;
    wait_n(100);
    est_in = 1'b1;
    wait_n(110);
    clear_fault = 1'b1;
    wait_n(115);
    est_in      = 1'b0;
    clear_fault = 1'b0;
    wait_n(125);
    clear_fault = 1'b1;
    wait_n(126);
    clear_fault = 1'b0;
    wait_n(150);
    duty_sp[3:0] = 4'd5;
    wait_n(170);
    dir_req[0] = 1'b1;
    wait_n(182);

    // Epoch 2: reset lands while ch0 is in dead time; both channels restart
    // from zero with ch0 heading forward after a fresh dead time.
    expect_at(2, 1, K_BUSY, 0, 0);
    expect_at(2, 1, K_BUSY, 1, 1);
    win(2, 0, 0, 0);
    win(2, 0, 1, 0);
    win_dir(2, 1, 0, 3, 1, 0);
    win_dir(2, 1, 1, 6, 0, 1);
    win_dir(2, 2, 0, 5, 1, 0);
    win(2, 2, 1, 7);

    #2;
    epoch = 2;
    rst   = 1'b1;
    #1 check("async_reset_outputs", int'({motor_in3, motor_in4, motor_enb, ch_busy, fault}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;

    wait_n(30);
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    while (q.size() > 0) begin
      mon_item = q.pop_front();
      checks++;
      errors++;
      $display("FAIL unchecked %s ch%0d ep%0d n%0d", kname(mon_item.kind), mon_item.ch,
               mon_item.ep, mon_item.n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
